branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 159 +++++++++++++++
 tb/tb_branch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolution unit: a condition-code register plus a three-state
// resolver (IDLE -> EVAL -> RESP) that decides a conditional branch and
// computes the next PC. It also keeps a saturating count of taken branches.
// EVAL lasts two cycles. The first cycle registers the decision and the
// target. The second cycle enters RESP. With br_req sampled at edge N,
// br_valid rises after edge N+2.

module branch_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DISPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_we,
    input  logic [3:0]       flag_in,
    input  logic             br_req,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [DISPW-1:0] br_disp,
    input  logic             br_ack,
    output logic [3:0]       flags,
    output logic             br_busy,
    output logic             br_valid,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target,
    output logic [15:0]      taken_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StResp = 2'd2
    } state_t;

    localparam logic [2:0] CondBe  = 3'b000;
    localparam logic [2:0] CondBlt = 3'b001;
    localparam logic [2:0] CondBle = 3'b010;
    localparam logic [2:0] CondBne = 3'b011;
    localparam logic [2:0] CondB   = 3'b100;

    state_t           state_q;
    logic             eval_ph_q;  // 0: decision cycle, 1: hand-off cycle into RESP
    logic [3:0]       flags_q;
    // Captured {S,Z,V}. Carry does not take part in any supported condition.
    logic [2:0]       cflags_q;
    logic [2:0]       cond_q;
    logic [WIDTH-1:0] pc_q;
    logic [DISPW-1:0] disp_q;
    logic             taken_q;
    logic [WIDTH-1:0] target_q;
    logic [15:0]      cnt_q;

    logic             taken_d;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] disp_ext;
    logic [15:0]      cnt_d;
    logic             s_flag;
    logic             z_flag;
    logic             v_flag;

    assign s_flag = cflags_q[2];
    assign z_flag = cflags_q[1];
    assign v_flag = cflags_q[0];

    // Branch decision from the captured flags only.
    always_comb begin
        taken_d = 1'b0;
        case (cond_q)
            CondBe:  taken_d = z_flag;
            CondBlt: taken_d = s_flag ^ v_flag;
            CondBle: taken_d = z_flag | (s_flag ^ v_flag);
            CondBne: taken_d = ~z_flag;
            CondB:   taken_d = 1'b1;
            default: taken_d = 1'b0;
        endcase
    end

    // Next-PC arithmetic. It wraps modulo 2^WIDTH and has no overflow flag.
    always_comb begin
        disp_ext = {{(WIDTH - DISPW){disp_q[DISPW-1]}}, disp_q};
        seq_pc   = pc_q + WIDTH'(1);
        target_d = taken_d ? (seq_pc + disp_ext) : seq_pc;
    end

    // Saturating taken counter. The value is applied on the edge that enters RESP.
    always_comb begin
        cnt_d = cnt_q;
        if (taken_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Condition-code register. It is written whenever flag_we is high, in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (flag_we) begin
            flags_q <= flag_in;
        end
    end

    // Resolver FSM with registered result and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            eval_ph_q <= 1'b0;
            cflags_q  <= 3'b000;
            cond_q    <= 3'b000;
            pc_q      <= '0;
            disp_q    <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            cnt_q     <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (br_req) begin
                        cond_q    <= br_cond;
                        pc_q      <= br_pc;
                        disp_q    <= br_disp;
                        // A same-cycle flag write bypasses the register.
                        cflags_q  <= flag_we ? {flag_in[3], flag_in[2], flag_in[0]}
                                             : {flags_q[3], flags_q[2], flags_q[0]};
                        eval_ph_q <= 1'b0;
                        state_q   <= StEval;
                    end
                end
                StEval: begin
                    if (!eval_ph_q) begin
                        taken_q   <= taken_d;
                        target_q  <= target_d;
                        eval_ph_q <= 1'b1;
                    end else begin
                        eval_ph_q <= 1'b0;
                        cnt_q     <= cnt_d;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (br_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign flags     = flags_q;
    assign br_busy   = (state_q != StIdle);
    assign br_valid  = (state_q == StResp);
    assign br_taken  = taken_q;
    assign br_target = target_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit. Inputs change on the falling edge and
// outputs are sampled on the falling edge.

module tb_branch_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DISPW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flag_we;
    logic [3:0]       flag_in;
    logic             br_req;
    logic [2:0]       br_cond;
    logic [WIDTH-1:0] br_pc;
    logic [DISPW-1:0] br_disp;
    logic             br_ack;
    logic [3:0]       flags;
    logic             br_busy;
    logic             br_valid;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic [15:0]      taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_unit #(
        .WIDTH(WIDTH),
        .DISPW(DISPW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flag_we  (flag_we),
        .flag_in  (flag_in),
        .br_req   (br_req),
        .br_cond  (br_cond),
        .br_pc    (br_pc),
        .br_disp  (br_disp),
        .br_ack   (br_ack),
        .flags    (flags),
        .br_busy  (br_busy),
        .br_valid (br_valid),
        .br_taken (br_taken),
        .br_target(br_target),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_flags(input logic [3:0] f);
        flag_we = 1'b1;
        flag_in = f;
        step();
        flag_we = 1'b0;
    endtask

    // Issue one request and return in the cycle where br_valid should be high.
    task automatic resolve(input logic [2:0] c, input logic [15:0] pc, input logic [7:0] d);
        br_req  = 1'b1;
        br_cond = c;
        br_pc   = pc;
        br_disp = d;
        step();
        br_req = 1'b0;
        step();
        step();
    endtask

    task automatic ack();
        br_ack = 1'b1;
        step();
        br_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"},  32'(flags),     32'h0);
        check({tag, "_busy"},   32'(br_busy),   32'h0);
        check({tag, "_valid"},  32'(br_valid),  32'h0);
        check({tag, "_taken"},  32'(br_taken),  32'h0);
        check({tag, "_target"}, 32'(br_target), 32'h0);
        check({tag, "_cnt"},    32'(taken_cnt), 32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        flag_we = 1'b0;
        flag_in = 4'b0000;
        br_req  = 1'b0;
        br_cond = 3'b000;
        br_pc   = '0;
        br_disp = '0;
        br_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // BE taken, Z=1, with the latency checked cycle by cycle
        write_flags(4'b0100);
        check("flag_load", 32'(flags), 32'h4);
        br_req  = 1'b1;
        br_cond = 3'b000;
        br_pc   = 16'h0010;
        br_disp = 8'h05;
        step();
        br_req = 1'b0;
        check("lat_n0_busy", 32'(br_busy), 32'h1);
        check("lat_n0_valid", 32'(br_valid), 32'h0);
        step();
        check("lat_n1_valid", 32'(br_valid), 32'h0);
        step();
        check("lat_n2_valid", 32'(br_valid), 32'h1);
        check("be_taken", 32'(br_taken), 32'h1);
        check("be_target", 32'(br_target), 32'h0016);
        check("be_cnt", 32'(taken_cnt), 32'h1);
        ack();
        check("be_ack_valid", 32'(br_valid), 32'h0);
        check("be_ack_busy", 32'(br_busy), 32'h0);

        // BLT with S=1,V=0 is taken; with S=1,V=1 it is not taken
        write_flags(4'b1000);
        resolve(3'b001, 16'h0020, 8'hFE);
        check("blt_t_taken", 32'(br_taken), 32'h1);
        check("blt_t_target", 32'(br_target), 32'h001F);
        check("blt_t_cnt", 32'(taken_cnt), 32'h2);
        ack();
        write_flags(4'b1001);
        resolve(3'b001, 16'h0020, 8'hFE);
        check("blt_nt_taken", 32'(br_taken), 32'h0);
        check("blt_nt_target", 32'(br_target), 32'h0021);
        check("blt_nt_cnt", 32'(taken_cnt), 32'h2);
        ack();

        // BNE with the bypassed Z=1, then a flag write during EVAL
        write_flags(4'b0000);
        flag_we = 1'b1;
        flag_in = 4'b0100;
        br_req  = 1'b1;
        br_cond = 3'b011;
        br_pc   = 16'h0100;
        br_disp = 8'h10;
        step();
        br_req  = 1'b0;
        flag_in = 4'b0000;
        step();
        flag_we = 1'b0;
        check("bne_evalwr_flags", 32'(flags), 32'h0);
        step();
        check("bne_valid", 32'(br_valid), 32'h1);
        check("bne_taken", 32'(br_taken), 32'h0);
        check("bne_target", 32'(br_target), 32'h0101);
        check("bne_cnt", 32'(taken_cnt), 32'h2);
        ack();

        // Unconditional branch wraps from 0xFFFF, held RESP ignores a new request
        resolve(3'b100, 16'hFFFF, 8'h00);
        check("b_wrap_taken", 32'(br_taken), 32'h1);
        check("b_wrap_target", 32'(br_target), 32'h0000);
        check("b_wrap_cnt", 32'(taken_cnt), 32'h3);
        br_req  = 1'b1;
        br_cond = 3'b000;
        br_pc   = 16'h1234;
        br_disp = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", 32'(br_valid), 32'h1);
            check("hold_target", 32'(br_target), 32'h0000);
            check("hold_cnt", 32'(taken_cnt), 32'h3);
        end
        br_req = 1'b0;
        ack();
        check("hold_ack_valid", 32'(br_valid), 32'h0);
        step();
        check("no_queue_busy", 32'(br_busy), 32'h0);

        // Reserved code 110 is never taken, even with Z=1
        write_flags(4'b0100);
        resolve(3'b110, 16'h0050, 8'h03);
        check("c110_taken", 32'(br_taken), 32'h0);
        check("c110_target", 32'(br_target), 32'h0051);
        check("c110_cnt", 32'(taken_cnt), 32'h3);
        ack();

        // BLE taken on Z with the most negative displacement
        resolve(3'b010, 16'h0000, 8'h80);
        check("ble_taken", 32'(br_taken), 32'h1);
        check("ble_target", 32'(br_target), 32'hFF81);
        check("ble_cnt", 32'(taken_cnt), 32'h4);
        ack();

        // Saturation: preload the counter just below the top
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        resolve(3'b100, 16'h0200, 8'h01);
        check("sat1_target", 32'(br_target), 32'h0202);
        check("sat1_cnt", 32'(taken_cnt), 32'hFFFF);
        ack();
        resolve(3'b100, 16'h0200, 8'h01);
        check("sat2_cnt", 32'(taken_cnt), 32'hFFFF);
        ack();

        // Reset pulse during EVAL aborts the request
        resolve(3'b100, 16'h0300, 8'h02);
        ack();
        br_req  = 1'b1;
        br_cond = 3'b100;
        br_pc   = 16'h0300;
        br_disp = 8'h02;
        step();
        br_req = 1'b0;
        check("abort_busy_pre", 32'(br_busy), 32'h1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_valid", 32'(br_valid), 32'h0);
        end
        resolve(3'b100, 16'h0040, 8'h01);
        check("fresh_valid", 32'(br_valid), 32'h1);
        check("fresh_target", 32'(br_target), 32'h0042);
        check("fresh_cnt", 32'(taken_cnt), 32'h1);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
